// File: rtl/neuron_mac_lanes_if.sv
// Stream and configuration bus of one neuron_mac_lanes instance: the input
// beat handshake, the shared weight/bias configuration bus and the result
// handshake.
interface neuron_mac_lanes_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4
);
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        weight_valid;
    logic [31:0]                 weight_value;
    logic                        bias_valid;
    logic [31:0]                 bias_value;
    logic [31:0]                 config_layer_num;
    logic [31:0]                 config_neuron_num;
    logic [DATA_WIDTH-1:0]       out;
    logic                        out_valid;
    logic                        out_ready;

    // Producer / consumer side (drives beats, configuration and out_ready).
    modport master (
        output in_data, in_valid, weight_valid, weight_value, bias_valid,
               bias_value, config_layer_num, config_neuron_num, out_ready,
        input  in_ready, out, out_valid
    );

    // Neuron side.
    modport slave (
        input  in_data, in_valid, weight_valid, weight_value, bias_valid,
               bias_value, config_layer_num, config_neuron_num, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/neuron_mac_lanes.sv
// Multi-lane fully-connected neuron: LANES signed products per beat, a
// saturating accumulator, runtime-loadable bias and ReLU/linear activation
// with saturation into the DATA_WIDTH output format.
module neuron_mac_lanes #(
    parameter int LAYER_NO   = 1,
    parameter int NEURON_NO  = 0,
    parameter int NUM_WEIGHT = 784,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int INT_W      = 1,
    parameter     ACT_TYPE   = "relu"
) (
    input logic               clk,
    input logic               rst,
    neuron_mac_lanes_if.slave bus
);
    localparam int ACC_W  = 2 * DATA_WIDTH;
    localparam int SUM_W  = ACC_W + $clog2(LANES) + 1;
    localparam int NBEATS = NUM_WEIGHT / LANES;
    localparam int BEAT_W = $clog2(NBEATS + 1);
    localparam int ADDR_W = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam bit IS_LINEAR = (ACT_TYPE == "linear");

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACC   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_BIAS  = 3'd3;
    localparam logic [2:0] ST_ACT   = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;

    localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]   OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]   OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Sign-extend an accumulator-width value to the wide summation width.
    function automatic logic signed [SUM_W-1:0] sext_acc(input logic signed [ACC_W-1:0] v);
        return {{(SUM_W-ACC_W){v[ACC_W-1]}}, v};
    endfunction

    // Clamp a wide sum into the signed accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > SUM_MAX) begin
            r = ACC_MAX;
        end else if (v < SUM_MIN) begin
            r = ACC_MIN;
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    logic [2:0]                    state_r;
    logic [BEAT_W-1:0]             beat_cnt_r;
    logic                          drain_cnt_r;
    logic [ADDR_W-1:0]             wptr_r;
    logic signed [DATA_WIDTH-1:0]  weight_mem [NUM_WEIGHT];
    logic signed [DATA_WIDTH-1:0]  bias_r;
    logic signed [ACC_W-1:0]       prod_r [LANES];
    logic                          prod_valid_r;
    logic signed [ACC_W-1:0]       acc_r;
    logic [DATA_WIDTH-1:0]         out_r;
    logic                          out_valid_r;

    logic                          cfg_match_s;
    logic                          weight_hit_s;
    logic                          bias_hit_s;
    logic                          in_ready_s;
    logic                          beat_fire_s;
    logic                          last_beat_s;
    logic                          out_fire_s;
    logic [ADDR_W-1:0]             lane_addr_s   [LANES];
    logic signed [DATA_WIDTH-1:0]  lane_data_s   [LANES];
    logic signed [DATA_WIDTH-1:0]  lane_weight_s [LANES];
    logic signed [SUM_W-1:0]       prod_sum_s;
    logic signed [ACC_W-1:0]       acc_next_s;
    logic signed [ACC_W-1:0]       bias_next_s;
    logic [INT_W:0]                ovf_bits_s;
    logic                          overflow_s;
    logic [DATA_WIDTH-1:0]         q_s;
    logic [DATA_WIDTH-1:0]         act_s;

    // Handshake qualifiers; configuration is only honoured while idle.
    always_comb begin
        cfg_match_s  = (bus.config_layer_num == 32'(LAYER_NO)) &&
                       (bus.config_neuron_num == 32'(NEURON_NO));
        weight_hit_s = bus.weight_valid && cfg_match_s && (state_r == ST_IDLE);
        bias_hit_s   = bus.bias_valid && cfg_match_s && (state_r == ST_IDLE);
        in_ready_s   = !rst && ((state_r == ST_IDLE) || (state_r == ST_ACC));
        beat_fire_s  = bus.in_valid && in_ready_s;
        last_beat_s  = (beat_cnt_r == BEAT_W'(NBEATS - 1));
        out_fire_s   = out_valid_r && bus.out_ready;
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;

    // Split the beat into lanes and fetch the weight each lane multiplies by.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_addr_s[l]   = ADDR_W'(beat_cnt_r) * ADDR_W'(LANES) + ADDR_W'(l);
            lane_data_s[l]   = bus.in_data[l*DATA_WIDTH +: DATA_WIDTH];
            lane_weight_s[l] = weight_mem[lane_addr_s[l]];
        end
    end

    // Full-width lane sum plus the saturated accumulate and bias candidates.
    always_comb begin
        prod_sum_s = {SUM_W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            prod_sum_s = prod_sum_s + sext_acc(prod_r[l]);
        end
        acc_next_s  = sat_acc(sext_acc(acc_r) + prod_sum_s);
        bias_next_s = sat_acc(sext_acc(acc_r) + sext_acc({bias_r, {DATA_WIDTH{1'b0}}}));
    end

    // Output slice with saturation when the integer bits overflow, then activation.
    always_comb begin
        ovf_bits_s = acc_r[ACC_W-1 -: INT_W+1];
        q_s        = acc_r[ACC_W-1-INT_W -: DATA_WIDTH];
        overflow_s = !((&ovf_bits_s) || !(|ovf_bits_s));
        if (!IS_LINEAR && acc_r[ACC_W-1]) begin
            act_s = {DATA_WIDTH{1'b0}};
        end else if (overflow_s) begin
            act_s = acc_r[ACC_W-1] ? OUT_MIN : OUT_MAX;
        end else begin
            act_s = q_s;
        end
    end

    // Weight storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (weight_hit_s) begin
            weight_mem[wptr_r] <= bus.weight_value[DATA_WIDTH-1:0];
        end
    end

    // Weight write pointer (wrapping) and bias register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= {ADDR_W{1'b0}};
            bias_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (weight_hit_s) begin
                wptr_r <= (wptr_r == ADDR_W'(NUM_WEIGHT - 1)) ? {ADDR_W{1'b0}} : wptr_r + ADDR_W'(1);
            end
            if (bias_hit_s) begin
                bias_r <= bus.bias_value[DATA_WIDTH-1:0];
            end
        end
    end

    // Stage 1: register one signed product per lane for every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_valid_r <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                prod_r[l] <= {ACC_W{1'b0}};
            end
        end else begin
            prod_valid_r <= beat_fire_s;
            if (beat_fire_s) begin
                for (int l = 0; l < LANES; l++) begin
                    prod_r[l] <= ACC_W'(lane_data_s[l]) * ACC_W'(lane_weight_s[l]);
                end
            end
        end
    end

    // Stage 2 accumulator: product accumulate, bias add, clear after hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if ((state_r == ST_HOLD) && out_fire_s) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (state_r == ST_BIAS) begin
            acc_r <= bias_next_s;
        end else if (prod_valid_r) begin
            acc_r <= acc_next_s;
        end
    end

    // Control sequence: idle, accumulate beats, drain pipeline, bias, activate, hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            beat_cnt_r  <= {BEAT_W{1'b0}};
            drain_cnt_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ACC: begin
                    drain_cnt_r <= 1'b0;
                    if (beat_fire_s) begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        state_r    <= last_beat_s ? ST_DRAIN : ST_ACC;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_r <= 1'b1;
                    if (drain_cnt_r) begin
                        state_r <= ST_BIAS;
                    end
                end
                ST_BIAS: begin
                    state_r <= ST_ACT;
                end
                ST_ACT: begin
                    state_r <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_fire_s) begin
                        state_r    <= ST_IDLE;
                        beat_cnt_r <= {BEAT_W{1'b0}};
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    beat_cnt_r <= {BEAT_W{1'b0}};
                end
            endcase
        end
    end

    // Result register: loaded in ACT, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r       <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else if (state_r == ST_ACT) begin
            out_r       <= act_s;
            out_valid_r <= 1'b1;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Bench for neuron_mac_lanes: a ReLU and a linear instance share one stimulus
// stream; results are predicted by an arithmetic model of the neuron.
module tb_neuron_mac_lanes;
    localparam int DW = 16;
    localparam int LN = 4;
    localparam int NW = 8;
    localparam int NB = NW / LN;

    typedef struct {
        logic [DW-1:0] relu;
        logic [DW-1:0] lin;
        int            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_mac_lanes_if #(.DATA_WIDTH(DW), .LANES(LN)) ifr ();
    neuron_mac_lanes_if #(.DATA_WIDTH(DW), .LANES(LN)) ifl ();

    assign ifl.in_data           = ifr.in_data;
    assign ifl.in_valid          = ifr.in_valid;
    assign ifl.weight_valid      = ifr.weight_valid;
    assign ifl.weight_value      = ifr.weight_value;
    assign ifl.bias_valid        = ifr.bias_valid;
    assign ifl.bias_value        = ifr.bias_value;
    assign ifl.config_layer_num  = ifr.config_layer_num;
    assign ifl.config_neuron_num = ifr.config_neuron_num;
    assign ifl.out_ready         = ifr.out_ready;

    neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(DW),
                       .LANES(LN), .INT_W(1), .ACT_TYPE("relu"))
        dut_relu (.clk(clk), .rst(rst), .bus(ifr));

    neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(DW),
                       .LANES(LN), .INT_W(1), .ACT_TYPE("linear"))
        dut_lin (.clk(clk), .rst(rst), .bus(ifl));

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int hs = 0;
    int sent = 0;
    bit rand_ready = 1'b0;
    exp_t exp_q[$];

    logic [DW-1:0] wm [NW];
    logic [DW-1:0] bias_m;
    int            wptr_m;
    logic [DW-1:0] vec_x [NW];

    logic          prev_ov = 1'b0;
    logic [DW-1:0] held_r;
    logic [DW-1:0] held_l;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!rst && ifr.out_valid && ifr.out_ready) hs <= hs + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Arithmetic model: dot product with per-beat saturation, bias scaled by
    // 2^DW, result = acc / 2^15 clamped to 16-bit signed, ReLU zeroes negatives.
    task automatic model_compute(output longint acc, output logic [DW-1:0] r, output logic [DW-1:0] l);
        longint s;
        longint q;
        acc = 0;
        for (int b = 0; b < NB; b++) begin
            s = 0;
            for (int k = 0; k < LN; k++)
                s += longint'($signed(vec_x[b*LN+k])) * longint'($signed(wm[b*LN+k]));
            acc = sat32(acc + s);
        end
        acc = sat32(acc + longint'($signed(bias_m)) * 65536);
        q = acc >>> 15;
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        l = 16'(q);
        r = (acc < 0) ? 16'h0000 : 16'(q);
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ready) ifr.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic cfg(input bit is_bias, input logic [DW-1:0] v, input int layer, input int neuron);
        ifr.config_layer_num  = 32'(layer);
        ifr.config_neuron_num = 32'(neuron);
        if (is_bias) begin
            ifr.bias_valid = 1'b1;
            ifr.bias_value = {16'($urandom), v};
        end else begin
            ifr.weight_valid = 1'b1;
            ifr.weight_value = {16'($urandom), v};
        end
        tick();
        ifr.bias_valid   = 1'b0;
        ifr.weight_valid = 1'b0;
        if (layer == 1 && neuron == 0) begin
            if (is_bias) bias_m = v;
            else begin
                wm[wptr_m] = v;
                wptr_m = (wptr_m + 1) % NW;
            end
        end
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < NW; i++) vec_x[i] = v;
    endtask

    task automatic load_weights(input logic [DW-1:0] v);
        for (int i = 0; i < NW; i++) cfg(1'b0, v, 1, 0);
    endtask

    // Sends nbeats beats of vec_x; a full vector is pushed to the expectation queue.
    task automatic send_vector(input int gap, input int nbeats, input bit inject,
                               output longint acc_o, output logic [DW-1:0] r_o, output logic [DW-1:0] l_o);
        int g;
        int last_cyc;
        last_cyc = 0;
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < LN; k++) ifr.in_data[k*DW +: DW] = vec_x[b*LN+k];
            ifr.in_valid = 1'b1;
            g = 0;
            while (!ifr.in_ready && g < 300) begin tick(); g++; end
            if (!ifr.in_ready) begin
                chk("beat_accept_timeout", ifr.in_ready, 1);
                ifr.in_valid = 1'b0;
                return;
            end
            tick();
            ifr.in_valid = 1'b0;
            last_cyc = cyc;
            if (inject && b == 0) begin
                ifr.config_layer_num  = 32'd1;
                ifr.config_neuron_num = 32'd0;
                ifr.weight_value      = 32'h0000_1111;
                ifr.weight_valid      = 1'b1;
                tick();
                ifr.weight_valid      = 1'b0;
            end
            repeat (gap) tick();
        end
        model_compute(acc_o, r_o, l_o);
        if (nbeats == NB) begin
            exp_q.push_back('{relu: r_o, lin: l_o, last: last_cyc});
            sent++;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (hs != sent && g < 500) begin tick(); g++; end
        if (hs != sent) chk("idle_timeout", hs, sent);
    endtask

    // Compare process: result values, latency, hold stability and pairing of instances.
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) prev_ov = 1'b0;
            else begin
                chk("ov_relu_vs_linear", ifl.out_valid, ifr.out_valid);
                if (ifr.out_valid && !prev_ov) begin
                    if (exp_q.size() == 0) chk("spurious_out_valid", ifr.out_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_relu", ifr.out, e.relu);
                        chk("out_linear", ifl.out, e.lin);
                        chk("latency", cyc, e.last + 4);
                    end
                    held_r = ifr.out;
                    held_l = ifl.out;
                end else if (ifr.out_valid) begin
                    chk("hold_relu", ifr.out, held_r);
                    chk("hold_linear", ifl.out, held_l);
                    chk("in_ready_in_hold", ifr.in_ready, 0);
                end
                prev_ov = ifr.out_valid;
            end
        end
    end

    initial begin : stim
        longint a;
        logic [DW-1:0] r, l, v;
        int g;
        ifr.in_data = '0;
        ifr.in_valid = 1'b0;
        ifr.weight_valid = 1'b0;
        ifr.weight_value = 32'h0;
        ifr.bias_valid = 1'b0;
        ifr.bias_value = 32'h0;
        ifr.config_layer_num = 32'h0;
        ifr.config_neuron_num = 32'h0;
        ifr.out_ready = 1'b1;
        bias_m = 16'h0000;
        wptr_m = 0;
        for (int i = 0; i < NW; i++) wm[i] = 16'h0000;

        // Reset values.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", ifr.in_ready, 0);
        chk("rst_out_valid", ifr.out_valid, 0);
        chk("rst_out", ifr.out, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", ifr.in_ready, 1);

        // Basic product sum and latency.
        load_weights(16'h2000);
        cfg(1'b1, 16'h0000, 1, 0);
        fill(16'h2000);
        send_vector(0, NB, 1'b0, a, r, l);
        chk("s1_model_out", r, 16'h4000);
        wait_idle();

        // Bias.
        cfg(1'b1, 16'h0010, 1, 0);
        send_vector(0, NB, 1'b0, a, r, l);
        chk("s2_model_acc", a, 64'h2010_0000);
        chk("s2_model_out", r, 16'h4020);
        wait_idle();

        // Negative result: ReLU clips, linear passes.
        cfg(1'b1, 16'h0000, 1, 0);
        fill(16'hE000);
        send_vector(0, NB, 1'b0, a, r, l);
        chk("s3_model_relu", r, 16'h0000);
        chk("s3_model_linear", l, 16'hC000);
        wait_idle();

        // Accumulator saturation.
        load_weights(16'h4000);
        fill(16'h4000);
        send_vector(0, NB, 1'b0, a, r, l);
        chk("s3_model_sat_acc", a, 64'h7FFF_FFFF);
        chk("s3_model_sat_out", r, 16'h7FFF);
        wait_idle();

        // Backpressure on the result.
        load_weights(16'h2000);
        ifr.out_ready = 1'b0;
        fill(16'h2000);
        send_vector(0, NB, 1'b0, a, r, l);
        g = 0;
        while (!ifr.out_valid && g < 50) begin tick(); g++; end
        chk("s4_out_valid_rise", ifr.out_valid, 1);
        fill(16'h1000);
        for (int k = 0; k < LN; k++) ifr.in_data[k*DW +: DW] = vec_x[k];
        ifr.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("s4_in_ready_blocked", ifr.in_ready, 0);
            tick();
        end
        ifr.out_ready = 1'b1;
        tick();
        ifr.in_valid = 1'b0;
        chk("s4_in_ready_after_hs", ifr.in_ready, 1);
        chk("s4_out_valid_dropped", ifr.out_valid, 0);
        send_vector(0, NB, 1'b0, a, r, l);
        chk("s4_model_second", r, 16'h2000);
        wait_idle();

        // Configuration filtering: foreign ids and writes outside IDLE are ignored.
        cfg(1'b0, 16'h7777, 1, 5);
        cfg(1'b0, 16'h7777, 3, 0);
        cfg(1'b1, 16'h7777, 2, 0);
        fill(16'h2000);
        send_vector(0, NB, 1'b1, a, r, l);
        chk("s5_model_out", r, 16'h4000);
        wait_idle();

        // Reset mid-vector discards it; bubbles do not change the result.
        send_vector(0, 1, 1'b0, a, r, l);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wptr_m = 0;
        bias_m = 16'h0000;
        repeat (10) tick();
        chk("s6_no_out_after_rst", ifr.out_valid, 0);
        send_vector(3, NB, 1'b0, a, r, l);
        chk("s6_model_out", r, 16'h4000);
        wait_idle();

        // Randomized vectors, weights, bias and consumer backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            wait_idle();
            if ($urandom_range(0, 3) == 0) begin
                cfg(1'b0, 16'($urandom), 1, 1 + $urandom_range(0, 5));
                for (int i = 0; i < NW; i++) begin
                    v = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) v = {{4{v[11]}}, v[11:0]};
                    cfg(1'b0, v, 1, 0);
                end
                v = 16'($urandom);
                cfg(1'b1, {{8{v[7]}}, v[7:0]}, 1, 0);
            end
            for (int i = 0; i < NW; i++) begin
                v = 16'($urandom);
                if ($urandom_range(0, 1) == 1) v = {{4{v[11]}}, v[11:0]};
                vec_x[i] = v;
            end
            send_vector($urandom_range(0, 2), NB, 1'b0, a, r, l);
        end
        wait_idle();
        rand_ready = 1'b0;
        ifr.out_ready = 1'b1;
        repeat (3) tick();
        chk("expected_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
